// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (order a..g,
// bit 6 = a) and the digit-slot numbering used by the display scanners.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit slots, right to left on the display.
    localparam logic [1:0] DIG_PU = 2'd0;  // product units
    localparam logic [1:0] DIG_PT = 2'd1;  // product tens
    localparam logic [1:0] DIG_B  = 2'd2;  // operand B
    localparam logic [1:0] DIG_A  = 2'd3;  // operand A

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
// Values 10..15 show a dash so a bad digit is visible rather than silent.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    output logic [6:0] seg_n
);

    // Pattern lookup; blank wins over any value.
    always_comb begin
        // NOTE: every path assigns seg_n (default first), so no latch is inferred.
        seg_n = SEG_DASH;
        if (blank) begin
            seg_n = SEG_BLANK;
        end else begin
            case (val)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/mult_disp_scan.sv
// Display stage for the 2-bit multiplier: snapshots A, B and A*B once per
// refresh frame and time-multiplexes them onto a 4-digit common-anode
// display (A | B | product tens | product units).
module mult_disp_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] a_in,
    input  logic [1:0] b_in,
    input  logic [3:0] p_in,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    localparam int             CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       a_sh;
    logic [1:0]       b_sh;
    logic [3:0]       p_sh;
    logic             valid;

    logic             cnt_last;
    logic             tens;
    logic [3:0]       units;
    logic [3:0]       dig_val;
    logic             dig_blank;
    logic [6:0]       dec_seg_n;

    assign cnt_last = (cnt == CNT_LAST);

    // Prescaler, digit index and once-per-frame snapshot of the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= DIG_PU;
            // NOTE: shadows are reset so a frame can never show stale data;
            // valid still gates them until the first snapshot.
            a_sh       <= '0;
            b_sh       <= '0;
            p_sh       <= '0;
            valid      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples
            // the pre-edge state, matching the hardware it describes.
            frame_tick <= 1'b0;
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                if (idx == DIG_A) begin
                    a_sh       <= a_in;
                    b_sh       <= b_in;
                    p_sh       <= p_in;
                    valid      <= 1'b1;
                    frame_tick <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Split the product into decimal digits and pick the digit for this slot.
    always_comb begin
        tens      = (p_sh >= 4'd10);
        units     = tens ? (p_sh - 4'd10) : p_sh;
        dig_val   = units;
        dig_blank = 1'b0;
        case (idx)
            DIG_PU: dig_val = units;
            DIG_PT: begin
                dig_val   = {3'b000, tens};
                dig_blank = !tens;
            end
            DIG_B:  dig_val = {2'b00, b_sh};
            default: dig_val = {2'b00, a_sh};
        endcase
    end

    seg7_decode u_dec (
        .val   (dig_val),
        .blank (dig_blank),
        .seg_n (dec_seg_n)
    );

    // Anode and segments register together so no cycle mixes two digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_BLANK;
            an_n  <= 4'hF;
        end else if (valid) begin
            seg_n <= dec_seg_n;
            an_n  <= ~(4'b0001 << idx);
        end else begin
            seg_n <= SEG_BLANK;
            an_n  <= 4'hF;
        end
    end

endmodule

// File: tb/tb_mult_disp_scan.sv
// Directed bench for mult_disp_scan with SCAN_DIV=4 (16-cycle frame).
// cyc counts rising edges since reset release; outputs are sampled on the
// falling edge after each rising edge. Data captured at edge 16k is shown
// at cyc 16k+1 .. 16k+16, digit d at cyc 16k+1+4d .. 16k+4+4d.
module tb_mult_disp_scan;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [1:0] a_in;
    logic [1:0] b_in;
    logic [3:0] p_in;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_tick;

    int cmp_cnt;
    int err_cnt;
    int cyc;

    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    logic       exp_ft;

    mult_disp_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .p_in       (p_in),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in  = 2'd3;
        b_in  = 2'd3;
        p_in  = 4'd9;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || frame_tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_hold: seg_n=%b an_n=%b ft=%b, want 1111111 1111 0",
                     seg_n, an_n, frame_tick);
        end
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 16) begin
            tick();
            exp_ft = (cyc == 16);
            cmp_cnt++;
            if (seg_n !== 7'h7F || an_n !== 4'hF || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL dark cyc%0d: seg_n=%b an_n=%b ft=%b, want 1111111 1111 %b",
                         cyc, seg_n, an_n, frame_tick, exp_ft);
            end
        end
    endtask

    // Frame captured at edge 16 (3x3=9); next inputs loaded mid-frame.
    task automatic test_3x3();
        exp_seg = '{S9, SB, S3, S3};
        while (cyc < 32) begin
            tick();
            if (cyc == 18) begin
                a_in = 2'd0;
                b_in = 2'd2;
                p_in = 4'd0;
            end
            exp_an = ~(4'b0001 << ((cyc - 17) / 4));
            exp_s  = exp_seg[(cyc - 17) / 4];
            exp_ft = (cyc == 32);
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL 3x3 cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
    endtask

    task automatic test_zero();
        exp_seg = '{S0, SB, S2, S0};
        while (cyc < 48) begin
            tick();
            if (cyc == 40) begin
                a_in = 2'd2;
                b_in = 2'd1;
                p_in = 4'd2;
            end
            exp_an = ~(4'b0001 << ((cyc - 33) / 4));
            exp_s  = exp_seg[(cyc - 33) / 4];
            exp_ft = (cyc == 48);
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL zero cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
    endtask

    // 2x1=2 frame; inputs switch to 3x2=6 while the tens digit is lit.
    task automatic test_mid_frame();
        exp_seg = '{S2, SB, S1, S2};
        while (cyc < 64) begin
            tick();
            if (cyc == 53) begin
                a_in = 2'd3;
                b_in = 2'd2;
                p_in = 4'd6;
            end
            exp_an = ~(4'b0001 << ((cyc - 49) / 4));
            exp_s  = exp_seg[(cyc - 49) / 4];
            exp_ft = (cyc == 64);
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL midframe_old cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
        exp_seg = '{S6, SB, S2, S3};
        while (cyc < 80) begin
            tick();
            // Out-of-range product arrives half a cycle before the snapshot edge.
            if (cyc == 79) begin
                a_in = 2'd3;
                b_in = 2'd3;
                p_in = 4'd12;
            end
            exp_an = ~(4'b0001 << ((cyc - 65) / 4));
            exp_s  = exp_seg[(cyc - 65) / 4];
            exp_ft = (cyc == 80);
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL midframe_new cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_seg = '{S2, S1, S3, S3};
        while (cyc < 96) begin
            tick();
            exp_an = ~(4'b0001 << ((cyc - 81) / 4));
            exp_s  = exp_seg[(cyc - 81) / 4];
            exp_ft = (cyc == 96);
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL p12 cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (cyc < 105) tick();
        cmp_cnt++;
        if (an_n !== 4'b1011 || seg_n !== S3) begin
            err_cnt++;
            $display("FAIL pre_reset_b: seg_n=%b an_n=%b, want %b 1011", seg_n, an_n, S3);
        end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || frame_tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: seg_n=%b an_n=%b ft=%b, want 1111111 1111 0",
                     seg_n, an_n, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 17) begin
            tick();
            exp_ft = (cyc == 16);
            exp_an = (cyc == 17) ? 4'b1110 : 4'hF;
            exp_s  = (cyc == 17) ? S2 : SB;
            cmp_cnt++;
            if (seg_n !== exp_s || an_n !== exp_an || frame_tick !== exp_ft) begin
                err_cnt++;
                $display("FAIL post_reset cyc%0d: seg_n=%b an_n=%b ft=%b, want %b %b %b",
                         cyc, seg_n, an_n, frame_tick, exp_s, exp_an, exp_ft);
            end
        end
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        p_in    = '0;
        test_reset();
        test_3x3();
        test_zero();
        test_mid_frame();
        test_out_of_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mult_disp_scan.md
# mult_disp_scan

Downstream display stage for the 2-bit multiplier board. Takes the operands and product, snapshots them once per refresh frame and drives a 4-digit common-anode 7-segment display by time multiplexing. Shows A, B and the decimal product on separate digits.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit. Legal range is ≥ 2.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset.
  - One clock.
  - Reset is asynchronous and active-low.
- `a_in`, in, 2: operand A. Unsigned, asynchronous to the frame.
- `b_in`, in, 2: operand B. Unsigned.
- `p_in`, in, 4: product A*B from the multiplier. Unsigned, 0..15 accepted.
- `seg_n`, out, 7: active-low segments, `seg_n[6]`=a … `seg_n[0]`=g. Registered.
- `an_n`, out, 4: active-low digit anodes; `an_n[i]` lights digit i. Registered.
- `frame_tick`, out, 1: one-cycle pulse in the cycle after a snapshot. Registered.

## Operation
- **Prescaler `cnt`** counts 0..SCAN_DIV-1 every cycle.
  - At terminal count: `cnt`←0 and digit index `idx` advances 0→1→2→3→0.
- **Snapshot.** At terminal count with `idx`==3 (frame wrap):
  - `a_in`, `b_in`, `p_in` are latched into shadow registers.
  - `valid`←1 (sticky until reset).
  - `frame_tick`←1 for one cycle.
  - Inputs changing mid-frame never alter the displayed frame.
- **Digit map:**
  - idx0 = product units.
  - idx1 = product tens.
  - idx2 = B.
  - idx3 = A.
- **Arithmetic:**
  - tens = (p ≥ 10); units = p − 10·tens. Both are 4-bit.
  - A and B are zero-extended to 4 bits.
- **Leading-zero blanking:** idx1 with tens==0 drives `seg_n`=7'b1111111. Its anode is still asserted.
- **Decode** (active-low, order a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - any value 10..15 = dash 1111110 (unreachable by construction; defensive only).
- **Output register.** Each cycle:
  - `an_n` ← ~(1<<idx) when `valid`, else 4'b1111.
  - `seg_n` ← decode of the selected shadow digit when `valid`, else 7'b1111111.
- **Before the first snapshot:** display fully dark.

## Timing
- **Reset values:**
  - `cnt`=0, `idx`=0.
  - shadows=0, `valid`=0.
  - `seg_n`=7'h7F, `an_n`=4'hF, `frame_tick`=0.
- **Output latency:** `seg_n`/`an_n` reflect `idx` with one cycle of latency. Anode and segments change in the same cycle, so no mixed-digit cycle exists.
- **First snapshot:** at cycle 4·SCAN_DIV−1 after reset release. `frame_tick` is high at cycle 4·SCAN_DIV. The first lit digit (idx0) appears at cycle 4·SCAN_DIV+1.
- **Steady state:** each digit lit for exactly SCAN_DIV cycles; frame period 4·SCAN_DIV.
- **`idx` wrap:** 3→0 coincides with the snapshot. idx0 of the new frame shows the new data.
- **Simultaneous events:** an input change on the snapshot cycle is captured; the value sampled at that edge wins.
- **Reset mid-frame:** immediate dark display; counters restart from 0; `valid` cleared.

## Structure
- **Package `seg7_pkg`:**
  - Active-low segment constants for 0–9, dash and blank.
  - Digit-index constants DIG_PU=0, DIG_PT=1, DIG_B=2, DIG_A=3.
- **Sub-module `seg7_decode`:** purely combinational, 4-bit value + blank flag → 7-bit active-low segments. Reusable by other boards in the codebase.
- **Top level:** prescaler, index counter, shadow registers, output registers.

## Test plan
All scenarios use SCAN_DIV=4 (frame = 16 cycles).
- **Reset/dark:** hold `rst_n`=0, then release → `seg_n`=7F, `an_n`=F through cycle 16. `frame_tick` pulses at cycle 16. `an_n`=1110 from cycle 17.
- **3×3=9:** A=3, B=3, p=9 →
  - idx0 `seg_n`=0000100.
  - idx1 blank 1111111 with `an_n`=1101.
  - idx2 and idx3 each 0000110.
  - each digit lit exactly 4 cycles.
- **Zero case:** A=0, B=2, p=0 →
  - units 0000001, tens blank.
  - B 0010010, A 0000001.
- **Mid-frame change:** switch inputs from 2×1=2 to 3×2=6 while idx=1 → rest of the frame still shows 2/1/2. The next frame shows 6/3/2, beginning right after `frame_tick`.
- **Out-of-range product:** force p=12 →
  - idx0 shows 2 (0010010).
  - idx1 shows 1 (1001111), not blank.
- **Reset mid-operation:** assert `rst_n` low while idx=2 → `an_n`=F and `seg_n`=7F asynchronously. After release, the full 4·SCAN_DIV dark period repeats.
